// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scan-code constants and decoder state encoding for ps2_key_ctrl
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_BREAK) || (b == SC_EXT);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - synchronous FIFO with a registered head word that holds its value when empty
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_nxt    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head is registered; when the new head slot is being written this edge, forward din.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) begin
                dout <= (do_push && (wr_ptr == rd_nxt)) ? din : mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 scan-code decoder, modifier tracking and key queue; optional TYPEMATIC_FILTER_EN
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] UNMAPPED = 8'h00
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic [7:0]                scan_code,
    input  logic                      scan_code_ready,
    input  logic [7:0]                ascii_in,
    output logic                      letter_case,
    output logic                      key_valid,
    output logic [7:0]                key_data,
    input  logic                      key_ready,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [3:0]                led_status
);
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_BRK     = BRK;
    localparam logic [1:0] ST_EXT     = EXT;
    localparam logic [1:0] ST_EXT_BRK = EXT_BRK;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       shift_l;
    logic       shift_r;
    logic       caps_lock;
    logic       shift_l_nxt;
    logic       shift_r_nxt;
    logic       caps_lock_nxt;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       repeat_make;
`ifdef TYPEMATIC_FILTER_EN
    logic [7:0] last_make;
    logic [7:0] last_make_nxt;
`endif

`ifdef TYPEMATIC_FILTER_EN
    assign repeat_make = (scan_code == last_make);
`else
    assign repeat_make = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        shift_l_nxt   = shift_l;
        shift_r_nxt   = shift_r;
        caps_lock_nxt = caps_lock;
        push          = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
        last_make_nxt = last_make;
`endif
        if (scan_code_ready) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == SC_BREAK) begin
                        state_nxt = ST_BRK;
                    end else if (scan_code == SC_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (!repeat_make) begin
`ifdef TYPEMATIC_FILTER_EN
                        last_make_nxt = scan_code;
`endif
                        case (scan_code)
                            SC_LSHIFT: shift_l_nxt   = 1'b1;
                            SC_RSHIFT: shift_r_nxt   = 1'b1;
                            SC_CAPS:   caps_lock_nxt = ~caps_lock;
                            default:   push          = (ascii_in != UNMAPPED);
                        endcase
                    end
                end
                ST_BRK: begin
                    if (scan_code == SC_LSHIFT) begin
                        shift_l_nxt = 1'b0;
                    end
                    if (scan_code == SC_RSHIFT) begin
                        shift_r_nxt = 1'b0;
                    end
`ifdef TYPEMATIC_FILTER_EN
                    if (scan_code == last_make) begin
                        last_make_nxt = 8'h00;
                    end
`endif
                    state_nxt = ST_IDLE;
                end
                ST_EXT: begin
                    state_nxt = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // letter_case is loaded from the next-state modifiers so it is valid for the very next byte.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            shift_l     <= 1'b0;
            shift_r     <= 1'b0;
            caps_lock   <= 1'b0;
            letter_case <= 1'b0;
            overflow    <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
            last_make   <= 8'h00;
`endif
        end else begin
            state       <= state_nxt;
            shift_l     <= shift_l_nxt;
            shift_r     <= shift_r_nxt;
            caps_lock   <= caps_lock_nxt;
            letter_case <= (shift_l_nxt | shift_r_nxt) ^ caps_lock_nxt;
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
`ifdef TYPEMATIC_FILTER_EN
            last_make   <= last_make_nxt;
`endif
        end
    end

    assign key_valid  = !fifo_empty;
    assign pop        = key_ready && key_valid;
    assign led_status = {overflow, key_valid, caps_lock, shift_l | shift_r};

    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_key_fifo (
        .clk    (sysclk),
        .resetn (reset),
        .push   (push),
        .din    (ascii_in),
        .pop    (pop),
        .dout   (key_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - self-checking bench for ps2_key_ctrl against a queue-based behavioural model
module tb_ps2_key_ctrl;
    localparam int DEPTH = 8;
`ifdef TYPEMATIC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_code_ready = 1'b0;
    logic [7:0] ascii_in;
    logic       letter_case;
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_ready = 1'b0;
    logic       overflow;
    logic [3:0] fifo_count;
    logic [3:0] led_status;

    int checks = 0;
    int failures = 0;

    always #5 sysclk = ~sysclk;

    function automatic logic [7:0] conv(input logic [7:0] b, input logic up);
        logic [7:0] c;
        case (b)
            8'h1C: c = 8'h61;
            8'h32: c = 8'h62;
            8'h21: c = 8'h63;
            8'h23: c = 8'h64;
            8'h24: c = 8'h65;
            8'h2B: c = 8'h66;
            8'h34: c = 8'h67;
            8'h33: c = 8'h68;
            8'h43: c = 8'h69;
            8'h16: c = 8'h31;
            8'h1E: c = 8'h32;
            8'h75: c = 8'h38;
            default: c = 8'h00;
        endcase
        if (up && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
        return c;
    endfunction

    assign ascii_in = conv(scan_code, letter_case);

    ps2_key_ctrl #(.DEPTH(DEPTH), .UNMAPPED(8'h00)) dut (
        .sysclk          (sysclk),
        .reset           (reset),
        .scan_code       (scan_code),
        .scan_code_ready (scan_code_ready),
        .ascii_in        (ascii_in),
        .letter_case     (letter_case),
        .key_valid       (key_valid),
        .key_data        (key_data),
        .key_ready       (key_ready),
        .overflow        (overflow),
        .fifo_count      (fifo_count),
        .led_status      (led_status)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: prefix flags, modifier bits and a queue of expected keys.
    logic [7:0] mq[$];
    bit         m_sl, m_sr, m_caps, m_ovf, m_brk, m_ext;
    logic [7:0] m_last, m_head, m_val;
    bit         m_pop, m_push, m_up;
    int         m_before;

    task automatic model_step();
        if (!reset) begin
            mq.delete();
            m_sl = 0; m_sr = 0; m_caps = 0; m_ovf = 0; m_brk = 0; m_ext = 0;
            m_last = 8'h00; m_head = 8'h00;
        end else begin
            m_pop    = key_ready && (mq.size() > 0);
            m_before = mq.size();
            m_push   = 0;
            m_val    = 8'h00;
            m_up     = (m_sl | m_sr) ^ m_caps;
            if (scan_code_ready) begin
                if (!m_brk && !m_ext) begin
                    if (scan_code == 8'hF0) m_brk = 1;
                    else if (scan_code == 8'hE0) m_ext = 1;
                    else if (!(FILTER && scan_code == m_last)) begin
                        m_last = scan_code;
                        if (scan_code == 8'h12) m_sl = 1;
                        else if (scan_code == 8'h59) m_sr = 1;
                        else if (scan_code == 8'h58) m_caps = ~m_caps;
                        else begin
                            m_val  = conv(scan_code, m_up);
                            m_push = (m_val != 8'h00);
                        end
                    end
                end else if (m_brk && !m_ext) begin
                    if (scan_code == 8'h12) m_sl = 0;
                    if (scan_code == 8'h59) m_sr = 0;
                    if (scan_code == m_last) m_last = 8'h00;
                    m_brk = 0;
                end else if (m_ext && !m_brk) begin
                    if (scan_code == 8'hF0) m_brk = 1;
                    else m_ext = 0;
                end else begin
                    m_ext = 0;
                    m_brk = 0;
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (m_before == DEPTH && !m_pop) m_ovf = 1;
                else mq.push_back(m_val);
            end
            if (mq.size() > 0) m_head = mq[0];
        end
    endtask

    task automatic compare();
        check("key_valid", key_valid, mq.size() > 0);
        check("key_data", key_data, m_head);
        check("fifo_count", fifo_count, mq.size());
        check("overflow", overflow, m_ovf);
        check("letter_case", letter_case, (m_sl | m_sr) ^ m_caps);
        check("led_status", led_status, {m_ovf, mq.size() > 0, m_caps, m_sl | m_sr});
    endtask

    always @(posedge sysclk) begin
        model_step();
        #2;
        compare();
    end

    task automatic pulse(input logic [7:0] b);
        @(negedge sysclk);
        scan_code = b;
        scan_code_ready = 1'b1;
        @(negedge sysclk);
        scan_code_ready = 1'b0;
    endtask

    task automatic pop_one(input logic [7:0] exp, input string name);
        check(name, key_data, exp);
        key_ready = 1'b1;
        @(negedge sysclk);
        key_ready = 1'b0;
    endtask

    task automatic drain();
        key_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && fifo_count != 0; i++) @(negedge sysclk);
        key_ready = 1'b0;
        check("drain_empty", fifo_count, 0);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        reset = 1'b1;
    endtask

    logic [7:0] pool [18] = '{8'h12, 8'h59, 8'h58, 8'hF0, 8'hF0, 8'hE0, 8'h1C, 8'h32, 8'h21,
                              8'h23, 8'h24, 8'h2B, 8'h1C, 8'h43, 8'h16, 8'h1E, 8'h75, 8'h05};
    logic [7:0] order [8] = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h31};
    int ready_bias;

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge sysclk);
        check("rst_key_valid", key_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_led_status", led_status, 4'h0);
        check("rst_key_data", key_data, 8'h00);
        reset = 1'b1;

        // plain key and push latency
        @(negedge sysclk);
        scan_code = 8'h1C;
        scan_code_ready = 1'b1;
        check("lat_before", key_valid, 0);
        @(negedge sysclk);
        scan_code_ready = 1'b0;
        check("lat_after", key_valid, 1);
        check("plain_data", key_data, 8'h61);
        pulse(8'hF0);
        pulse(8'h1C);
        check("plain_count", fifo_count, 1);
        drain();

        // shift
        pulse(8'h12);
        check("shift_case_on", letter_case, 1);
        pulse(8'h1C);
        pulse(8'hF0);
        pulse(8'h1C);
        pulse(8'hF0);
        pulse(8'h12);
        check("shift_case_off", letter_case, 0);
        pulse(8'h1C);
        check("shift_count", fifo_count, 2);
        pop_one(8'h41, "shift_key0");
        pop_one(8'h61, "shift_key1");

        // caps lock
        pulse(8'h58);
        check("caps_led_on", led_status[1], 1);
        pulse(8'h1C);
        pulse(8'h58);
        check("caps_led_off", led_status[1], 0);
        pulse(8'h1C);
        pop_one(8'h41, "caps_key0");
        pop_one(8'h61, "caps_key1");

        // extended stream queues nothing and returns to IDLE
        pulse(8'hE0); pulse(8'h75); pulse(8'hE0); pulse(8'hF0); pulse(8'h75);
        check("ext_count", fifo_count, 0);
        pulse(8'h75);
        check("ext_then_make", fifo_count, 1);
        pop_one(8'h38, "ext_make_key");

        // overflow
        pulse(8'h1C); pulse(8'h32); pulse(8'h21); pulse(8'h23); pulse(8'h24);
        pulse(8'h2B); pulse(8'h34); pulse(8'h33); pulse(8'h43);
        check("ovf_count", fifo_count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_head", key_data, 8'h61);
        @(negedge sysclk);
        scan_code = 8'h16;
        scan_code_ready = 1'b1;
        key_ready = 1'b1;
        @(negedge sysclk);
        scan_code_ready = 1'b0;
        key_ready = 1'b0;
        check("full_pushpop_count", fifo_count, 8);
        for (int i = 0; i < 8; i++) pop_one(order[i], $sformatf("ovf_order%0d", i));
        check("ovf_sticky", overflow, 1);

        // reset mid-prefix with keys queued
        pulse(8'h12);
        pulse(8'h1C); pulse(8'h32); pulse(8'h21); pulse(8'h23); pulse(8'h24);
        check("pre_rst_count", fifo_count, 5);
        pulse(8'hE0);
        do_reset();
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_case", letter_case, 0);
        pulse(8'h1C);
        check("post_rst_count", fifo_count, 1);
        check("post_rst_data", key_data, 8'h61);

        // typematic repeat
        do_reset();
        pulse(8'h1C); pulse(8'h1C); pulse(8'h1C); pulse(8'hF0); pulse(8'h1C); pulse(8'h1C);
        check("typematic_count", fifo_count, FILTER ? 2 : 4);
        drain();

        // randomized traffic
        ready_bias = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge sysclk);
            if (i % 200 == 0) ready_bias = $urandom_range(0, 3);
            reset = ($urandom_range(0, 399) != 0);
            scan_code = pool[$urandom_range(0, 17)];
            scan_code_ready = ($urandom_range(0, 2) != 0);
            key_ready = ($urandom_range(0, 3) < ready_bias);
        end
        @(negedge sysclk);
        reset = 1'b1;
        scan_code_ready = 1'b0;
        key_ready = 1'b0;
        repeat (2) @(negedge sysclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
